// File: rtl/cr_kme_fifo_writer_if.sv
// rtl/cr_kme_fifo_writer_if.sv - source word stream and FIFO write port bundle
interface cr_kme_fifo_writer_if;
  logic         in_valid;
  logic [63:0]  in_data;
  logic         in_sot;
  logic         in_eot;
  logic [2:0]   in_tag;
  logic         in_ack;
  logic [262:0] fifo_in;
  logic         fifo_in_valid;
  logic         fifo_in_stall;

  // Writer side: consumes the word stream, drives the FIFO write port
  modport slave (
    input  in_valid, in_data, in_sot, in_eot, in_tag, fifo_in_stall,
    output in_ack, fifo_in, fifo_in_valid
  );

  // Environment side: frame source plus the FIFO itself
  modport master (
    output in_valid, in_data, in_sot, in_eot, in_tag, fifo_in_stall,
    input  in_ack, fifo_in, fifo_in_valid
  );
endinterface

// File: rtl/cr_kme_fifo_writer.sv
// rtl/cr_kme_fifo_writer.sv - packs 64-bit frame words into 263-bit KME FIFO entries
module cr_kme_fifo_writer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cr_kme_fifo_writer_if.slave bus,
  input  logic             err_clr,
  output logic             proto_err,
  output logic [CNT_W-1:0] entry_cnt
);

  logic [1:0]       widx_q, widx_d;
  logic             in_frame_q, in_frame_d;
  logic             asm_sot_q, asm_sot_d;
  logic [2:0]       asm_tag_q, asm_tag_d;
  logic [255:0]     asm_data_q, asm_data_d;
  logic             stage_valid_q, stage_valid_d;
  logic [262:0]     stage_q, stage_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] entry_cnt_q, entry_cnt_d;

  logic [1:0]   eff_widx;
  logic         take;
  logic         completing;
  logic         fifo_wr;
  logic         ack;
  logic         proto_set;
  logic         entry_sot;
  logic [2:0]   entry_tag;
  logic [255:0] merged;

  assign bus.in_ack        = ack;
  assign bus.fifo_in       = stage_q;
  assign bus.fifo_in_valid = fifo_wr;
  assign proto_err         = proto_err_q;
  assign entry_cnt         = entry_cnt_q;

  // Acceptance, assembly/stage next state, error flag and entry counter
  always_comb begin
    // A sot word always restarts assembly at index 0, even mid-frame
    eff_widx   = bus.in_sot ? 2'd0 : widx_q;
    // Words outside a frame without sot are dropped, so they never complete
    take       = bus.in_valid & (bus.in_sot | in_frame_q);
    completing = take & ((eff_widx == 2'd3) | bus.in_eot);
    fifo_wr    = stage_valid_q & ~bus.fifo_in_stall;
    ack        = bus.in_valid & (~completing | ~stage_valid_q | fifo_wr);
    proto_set  = bus.in_valid & ack & (bus.in_sot ? in_frame_q : ~in_frame_q);

    entry_sot  = bus.in_sot | asm_sot_q;
    entry_tag  = bus.in_sot ? bus.in_tag : asm_tag_q;
    merged     = bus.in_sot ? 256'd0 : asm_data_q;
    merged[{eff_widx, 6'd0} +: 64] = bus.in_data;

    widx_d        = widx_q;
    in_frame_d    = in_frame_q;
    asm_sot_d     = asm_sot_q;
    asm_tag_d     = asm_tag_q;
    asm_data_d    = asm_data_q;
    stage_d       = stage_q;
    stage_valid_d = stage_valid_q & ~fifo_wr;
    proto_err_d   = proto_err_q;
    entry_cnt_d   = entry_cnt_q;

    if (take && ack) begin
      asm_tag_d = entry_tag;
      if (completing) begin
        stage_valid_d = 1'b1;
        stage_d       = {entry_sot, bus.in_eot, eff_widx, entry_tag, merged};
        widx_d        = 2'd0;
        asm_data_d    = 256'd0;
        asm_sot_d     = 1'b0;
        in_frame_d    = ~bus.in_eot;
      end else begin
        widx_d        = eff_widx + 2'd1;
        asm_data_d    = merged;
        asm_sot_d     = entry_sot;
        in_frame_d    = 1'b1;
      end
    end

    if (err_clr) proto_err_d = 1'b0;
    if (proto_set) proto_err_d = 1'b1;

    if (fifo_wr && (entry_cnt_q != {CNT_W{1'b1}})) entry_cnt_d = entry_cnt_q + 1'b1;
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      widx_q        <= 2'd0;
      in_frame_q    <= 1'b0;
      asm_sot_q     <= 1'b0;
      asm_tag_q     <= 3'd0;
      asm_data_q    <= 256'd0;
      stage_valid_q <= 1'b0;
      stage_q       <= 263'd0;
      proto_err_q   <= 1'b0;
      entry_cnt_q   <= '0;
    end else begin
      widx_q        <= widx_d;
      in_frame_q    <= in_frame_d;
      asm_sot_q     <= asm_sot_d;
      asm_tag_q     <= asm_tag_d;
      asm_data_q    <= asm_data_d;
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
      proto_err_q   <= proto_err_d;
      entry_cnt_q   <= entry_cnt_d;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_writer.sv
// tb/tb_cr_kme_fifo_writer.sv - scoreboard and vector-table bench for cr_kme_fifo_writer
module tb_cr_kme_fifo_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        proto_err;
  logic [15:0] entry_cnt;

  cr_kme_fifo_writer_if bus();

  cr_kme_fifo_writer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .err_clr(err_clr), .proto_err(proto_err), .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [63:0] wq_t[$];
  typedef struct {
    int         len;
    logic [2:0] tag;
    int         exp_entries;
    logic [6:0] exp_last_hdr;
  } vec_t;

  int           tests = 0;
  int           fails = 0;
  logic [262:0] exp_q[$];
  logic [6:0]   last_hdr = 7'd0;

  task automatic check(input string name, input logic [262:0] act, input logic [262:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every FIFO write must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && bus.fifo_in_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got entry %0h required none", bus.fifo_in);
      end else begin
        check("entry", bus.fifo_in, exp_q.pop_front());
        last_hdr = bus.fifo_in[262:256];
      end
    end
  end

  task automatic push_frame(input wq_t w, input logic [2:0] tag);
    logic [262:0] e;
    int n;
    int cnt;
    n = w.size();
    for (int c = 0; c * 4 < n; c++) begin
      e = '0;
      cnt = (n - 4 * c > 4) ? 4 : n - 4 * c;
      for (int k = 0; k < cnt; k++) e[64 * k +: 64] = w[4 * c + k];
      e[262] = (c == 0);
      e[261] = (4 * c + cnt == n);
      e[260:259] = 2'(cnt - 1);
      e[258:256] = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic s, input logic e, input logic [2:0] t);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sot   = s;
    bus.in_eot   = e;
    bus.in_tag   = t;
    @(negedge clk);
    while (!bus.in_ack && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ack) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got in_ack 0 required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [2:0] tag);
    wq_t w;
    for (int i = 0; i < len; i++) w.push_back({$urandom, $urandom});
    push_frame(w, tag);
    for (int i = 0; i < len; i++)
      send_word(w[i], i == 0, i == len - 1, (i == 0) ? tag : ~tag);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[6];
  logic [15:0] c0;
  logic        ack_low;

  initial begin
    vecs[0] = '{4, 3'd5, 1, 7'b1111101};
    vecs[1] = '{6, 3'd3, 2, 7'b0101011};
    vecs[2] = '{1, 3'd0, 1, 7'b1100000};
    vecs[3] = '{8, 3'd7, 2, 7'b0111111};
    vecs[4] = '{5, 3'd2, 2, 7'b0100010};
    vecs[5] = '{3, 3'd1, 1, 7'b1110001};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sot = 1'b0;
    bus.in_eot = 1'b0; bus.in_tag = '0; bus.fifo_in_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_in_valid", bus.fifo_in_valid, 0);
    check("rst_fifo_in", bus.fifo_in, 0);
    check("rst_entry_cnt", entry_cnt, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_in_ack", bus.in_ack, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word without sot after reset is dropped and flagged
    send_word(64'h1234, 1'b0, 1'b0, 3'd0);
    check("nosot_proto_err", proto_err, 1);
    check("nosot_entry_cnt", entry_cnt, 0);
    err_clr = 1'b1;
    send_word(64'h5678, 1'b0, 1'b1, 3'd0);
    err_clr = 1'b0;
    check("set_beats_clr", proto_err, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr", proto_err, 0);

    for (int i = 0; i < 6; i++) begin
      c0 = entry_cnt;
      send_frame(vecs[i].len, vecs[i].tag);
      check("latency_valid", bus.fifo_in_valid, 1);
      wait_drain();
      check("vec_entries", entry_cnt - c0, vecs[i].exp_entries);
      check("vec_last_hdr", last_hdr, vecs[i].exp_last_hdr);
    end
    check("vec_proto_err", proto_err, 0);

    // Stall held for 10 cycles under two back-to-back 8-word frames
    c0 = entry_cnt;
    ack_low = 1'b0;
    bus.fifo_in_stall = 1'b1;
    fork
      begin
        send_frame(8, 3'd4);
        send_frame(8, 3'd2);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          check("stall_no_write", bus.fifo_in_valid, 0);
          if (bus.in_valid && !bus.in_ack) ack_low = 1'b1;
        end
        bus.fifo_in_stall = 1'b0;
      end
    join
    check("stall_ack_low", ack_low, 1);
    wait_drain();
    check("stall_entries", entry_cnt - c0, 4);

    // sot arriving at widx 2 discards the partial entry
    c0 = entry_cnt;
    send_word(64'hAAAA, 1'b1, 1'b0, 3'd1);
    send_word(64'hBBBB, 1'b0, 1'b0, 3'd1);
    send_frame(4, 3'd6);
    check("resync_proto_err", proto_err, 1);
    wait_drain();
    check("resync_entries", entry_cnt - c0, 1);
    check("resync_hdr", last_hdr, 7'b1111110);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("resync_err_clr", proto_err, 0);

    // Reset with a staged entry under stall and a partial assembly
    bus.fifo_in_stall = 1'b1;
    send_frame(4, 3'd3);
    send_word(64'hCCCC, 1'b1, 1'b0, 3'd2);
    send_word(64'hDDDD, 1'b0, 1'b0, 3'd2);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_fifo_in_valid", bus.fifo_in_valid, 0);
    check("midrst_entry_cnt", entry_cnt, 0);
    rst_n = 1'b1;
    bus.fifo_in_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_frame(3, 3'd5);
    wait_drain();
    check("postrst_entry_cnt", entry_cnt, 1);
    check("postrst_hdr", last_hdr, 7'b1110101);
    check("postrst_proto_err", proto_err, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
